exmem_port_arbiter: RTL
=======================

# exmem_port_arbiter

Shares the single Wishbone slave port of the external-memory controller (`user_proj_example`) between two requesters: the instruction prefetch cache (port 0, line refills only) and the data cache/write path (port 1, line refills or single-word writes). It grants requests round-robin and sequences each granted transaction on the memory bus. Line refills are issued as LINE_WORDS consecutive word reads. Returned words are delivered on one shared response channel tagged with port and word index. It sits in `user_project_wrapper` between the cache logic and `mprj_sdr`.

## Interface
- LINE_WORDS, 8: words per line refill; power of 2, range 2..16.
- IDX_W, $clog2(LINE_WORDS): width of the word index.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 line-refill request.
- req0_adr  in  32  port 0 address; bits [IDX_W+1:0] are ignored.
- req0_ready  out  1  one-cycle accept pulse.
- req1_valid  in  1  port 1 request.
- req1_we  in  1  1 = single-word write, 0 = line refill.
- req1_adr  in  32  port 1 address; word-aligned for writes, line base for refills.
- req1_dat  in  32  write data.
- req1_sel  in  4  write byte enables.
- req1_ready  out  1  one-cycle accept pulse.
- rsp_valid  out  1  response beat valid.
- rsp_port  out  1  port that owns the beat.
- rsp_idx  out  IDX_W  word index within the line (0 for writes).
- rsp_dat  out  32  read data (0 for write completion).
- rsp_last  out  1  final beat of the transaction.
- m_cyc_o, m_stb_o  out  1  Wishbone master cycle/strobe toward exmem.
- m_we_o  out  1  write enable.
- m_sel_o  out  4  byte select.
- m_adr_o  out  32  address.
- m_dat_o  out  32  write data.
- m_ack_i  in  1  slave acknowledge.
- m_dat_i  in  32  slave read data.
- busy  out  1  high when the state is not IDLE.

## Operation
- States: IDLE, RD_BURST, WR_SINGLE.
- IDLE: if any valid is high, grant one port. Capture its adr/we/dat/sel. Pulse that port's ready combinationally in the same cycle. Move to RD_BURST (port 0, or port 1 with we=0) or WR_SINGLE (port 1 with we=1).
- Arbitration: round-robin on the `last` flag.
  - `last` resets to 1, so port 0 wins the first conflict.
  - On a simultaneous request, grant the port that is not `last`.
  - `last` updates on every grant.
  - A lone request is granted immediately regardless of `last`.
- Requester rules:
  - Hold valid and all fields stable until ready.
  - Valid still high in the cycle after ready counts as a new request.
- RD_BURST:
  - Hold m_cyc_o = m_stb_o = 1 and m_we_o = 0, with m_sel_o = 4'hF.
  - m_adr_o = {base[31:IDX_W+2], cnt, 2'b00}; cnt starts at 0.
  - On each m_ack_i, cnt increments and m_adr_o advances on the next edge.
  - On the ack with cnt = LINE_WORDS-1, drop cyc/stb on the next edge and return to IDLE.
  - cnt is IDX_W bits and never wraps within a burst.
- WR_SINGLE:
  - Drive cyc/stb/we = 1 with the captured adr/dat/sel.
  - On m_ack_i, drop cyc/stb/we on the next edge and return to IDLE.
- Response channel:
  - Registered. rsp_valid is high in the cycle after each accepted ack.
  - Carries the ack's m_dat_i (0 for writes), the current cnt as rsp_idx, and the grant port as rsp_port.
  - rsp_last is 1 on the final beat. rsp_valid is a single-cycle pulse.
  - rsp_dat, rsp_idx and rsp_port hold their values between beats.
- m_ack_i while m_cyc_o = 0 is ignored.
- Reset (including mid-burst): all outputs go to 0 on the next edge, state returns to IDLE, cnt = 0, `last` = 1. A partial line is not resumed; the requester re-issues it.

## Timing
- Accept at cycle T (IDLE, ready = 1) → m_cyc_o first high at T+1.
- Ack at cycle A → rsp_valid at A+1.
- Ack of the final word at cycle F:
  - F+1: m_cyc_o = 0, state IDLE, rsp_valid with rsp_last = 1.
  - A pending request may be accepted in F+1, with the new m_cyc_o at F+2.
- Minimum gap between bus cycles is 1 idle cycle.
- Minimum line refill with a zero-wait slave: LINE_WORDS+2 cycles from accept to rsp_last.
- busy is registered and is 1 from T+1 through F.

## Test plan
- Port 0 refill at 0x3800_0120, slave acks every cycle: m_adr_o steps 0x3800_0120, 0x124 … 0x13C. 8 rsp beats on port 0 with idx 0..7 carrying slave data. rsp_last on idx 7, 10 cycles after accept.
- Both ports valid in the same cycle after reset: port 0 granted first and port 1 immediately after port 0's rsp_last. Repeat the conflict: port 1 wins next, then port 0 again (alternation).
- Port 1 write to 0x3800_0604, dat 0xDEADBEEF, sel 4'b0011: one bus cycle with we = 1 and exact adr/dat/sel. One rsp beat with port = 1, idx = 0, dat = 0, last = 1.
- Slave with random 0–5 wait states per beat: cyc/stb stay high throughout, m_adr_o changes only after acks, and exactly 8 beats are delivered in order.
- wb_rst_i asserted after beat 3 of a refill: all outputs are 0 next cycle and no further rsp beats appear. A new refill after release starts at idx 0 with port 0 priority.
- req1 asserted during a port 0 burst: req1_ready stays 0 until the IDLE cycle after port 0's final ack, then pulses exactly once.

Source files
------------

// File: rtl/exmem_port_arbiter_if.sv
// Requester, response and Wishbone master signals of exmem_port_arbiter.
// slave = arbiter side, master = cache/memory environment side.
interface exmem_port_arbiter_if #(
    parameter int IDX_W = 3
);
    logic             req0_valid;
    logic [31:0]      req0_adr;
    logic             req0_ready;

    logic             req1_valid;
    logic             req1_we;
    logic [31:0]      req1_adr;
    logic [31:0]      req1_dat;
    logic [3:0]       req1_sel;
    logic             req1_ready;

    logic             rsp_valid;
    logic             rsp_port;
    logic [IDX_W-1:0] rsp_idx;
    logic [31:0]      rsp_dat;
    logic             rsp_last;

    logic             m_cyc_o;
    logic             m_stb_o;
    logic             m_we_o;
    logic [3:0]       m_sel_o;
    logic [31:0]      m_adr_o;
    logic [31:0]      m_dat_o;
    logic             m_ack_i;
    logic [31:0]      m_dat_i;

    logic             busy;

    modport slave (
        input  req0_valid, req0_adr,
        input  req1_valid, req1_we, req1_adr,
        input  req1_dat, req1_sel,
        input  m_ack_i, m_dat_i,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_port, rsp_idx,
        output rsp_dat, rsp_last,
        output m_cyc_o, m_stb_o, m_we_o,
        output m_sel_o, m_adr_o, m_dat_o,
        output busy
    );

    modport master (
        output req0_valid, req0_adr,
        output req1_valid, req1_we, req1_adr,
        output req1_dat, req1_sel,
        output m_ack_i, m_dat_i,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_port, rsp_idx,
        input  rsp_dat, rsp_last,
        input  m_cyc_o, m_stb_o, m_we_o,
        input  m_sel_o, m_adr_o, m_dat_o,
        input  busy
    );
endinterface

// File: rtl/exmem_port_arbiter.sv
// Round-robin sharing of the exmem Wishbone port between the
// instruction refill path (port 0) and the data path (port 1).
module exmem_port_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    exmem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_SINGLE
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] cnt, cnt_nx;
    logic             last, last_nx;
    logic             port, port_nx;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;
    logic [3:0]       sel_q;

    logic             grant0, grant1;
    logic             ack, final_beat;

    logic             rsp_valid_q;
    logic             rsp_port_q;
    logic [IDX_W-1:0] rsp_idx_q;
    logic [31:0]      rsp_dat_q;
    logic             rsp_last_q;

    // last = 1 means port 1 was served most recently
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !wb_rst_i) begin
            grant0 = bus.req0_valid &&
                     (!bus.req1_valid || last);
            grant1 = bus.req1_valid &&
                     (!bus.req0_valid || !last);
        end
    end

    assign ack        = bus.m_ack_i && state != IDLE;
    assign final_beat = state == WR_SINGLE ||
                        cnt == IDX_W'(LINE_WORDS - 1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        port_nx  = port;
        unique case (state)
            IDLE: begin
                if (grant0) begin
                    state_nx = RD_BURST;
                    port_nx  = 1'b0;
                    last_nx  = 1'b0;
                end else if (grant1) begin
                    state_nx = bus.req1_we ? WR_SINGLE
                                           : RD_BURST;
                    port_nx  = 1'b1;
                    last_nx  = 1'b1;
                end
            end
            RD_BURST: begin
                if (ack) begin
                    cnt_nx = cnt + 1'b1;
                    if (final_beat) state_nx = IDLE;
                end
            end
            WR_SINGLE: begin
                if (ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 1'b1;
            port        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_dat_q   <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            last        <= last_nx;
            port        <= port_nx;
            rsp_valid_q <= ack;
            if (grant0) begin
                adr_q <= bus.req0_adr;
                dat_q <= '0;
                sel_q <= 4'hF;
            end else if (grant1) begin
                adr_q <= bus.req1_adr;
                dat_q <= bus.req1_we ? bus.req1_dat : '0;
                sel_q <= bus.req1_we ? bus.req1_sel : 4'hF;
            end
            if (ack) begin
                rsp_port_q <= port;
                rsp_idx_q  <= cnt;
                rsp_dat_q  <= state == RD_BURST ?
                              bus.m_dat_i : '0;
                rsp_last_q <= final_beat;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign bus.m_cyc_o = state != IDLE;
    assign bus.m_stb_o = state != IDLE;
    assign bus.m_we_o  = state == WR_SINGLE;
    assign bus.m_sel_o = state == IDLE ? 4'h0 : sel_q;
    assign bus.m_dat_o = state == WR_SINGLE ? dat_q : '0;
    assign bus.m_adr_o =
        state == RD_BURST  ?
            {adr_q[31:IDX_W+2], cnt, 2'b00} :
        state == WR_SINGLE ? adr_q : '0;

    assign bus.busy = state != IDLE;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_port  = rsp_port_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_last  = rsp_last_q;
endmodule
